// File: rtl/sin_table_reader.sv
// rtl/sin_table_reader.sv - phase-accumulator read master for sin_table with valid/ready sample output
// Three-cycle fetch/capture/hold loop; phase advances on capture so HOLD already addresses the next sample.

module sin_table_reader #(
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tune_wr,
    input  logic [ACC_W-1:0]  tune_in,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0]  phase;
    logic [ACC_W-1:0]  phase_nxt;
    logic [ACC_W-1:0]  tune;
    logic [ACC_W-1:0]  tune_eff;
    logic [ADDR_W-1:0] phase_msbs;

    logic              rd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] sample_nxt;
    logic              sample_valid_nxt;

    // A tune write lands in the same edge's phase update, so bypass the register.
    assign tune_eff   = tune_wr ? tune_in : tune;
    assign phase_msbs = phase[ACC_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (sample_ready) begin
                    state_nxt = en ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_nxt           = 1'b0;
        addr_nxt         = addr;
        sample_nxt       = sample;
        sample_valid_nxt = sample_valid;
        phase_nxt        = phase;
        case (state)
            IDLE: begin
                sample_valid_nxt = 1'b0;
                if (en) begin
                    rd_nxt   = 1'b1;
                    addr_nxt = phase_msbs;
                end
            end
            FETCH: begin
                rd_nxt = 1'b0;
            end
            CAPTURE: begin
                sample_nxt       = d_in;
                sample_valid_nxt = 1'b1;
                phase_nxt        = phase + tune_eff;
            end
            HOLD: begin
                if (sample_ready) begin
                    sample_valid_nxt = 1'b0;
                    if (en) begin
                        rd_nxt   = 1'b1;
                        addr_nxt = phase_msbs;
                    end
                end
            end
            default: begin
                sample_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            tune         <= '0;
            rd           <= 1'b0;
            addr         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            tune         <= tune_eff;
            rd           <= rd_nxt;
            addr         <= addr_nxt;
            sample       <= sample_nxt;
            sample_valid <= sample_valid_nxt;
        end
    end

endmodule

// File: tb/tb_sin_table_reader.sv
// tb/tb_sin_table_reader.sv - directed self-checking bench for sin_table_reader with a sine ROM model
// The ROM model returns random bytes on cycles without a read so stray d_in captures show up.

module tb_sin_table_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        tune_wr = 1'b0;
    logic [15:0] tune_in = 16'h0000;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        sample_ready = 1'b1;

    logic [7:0]  rom [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cyc = 0;
    int          first_rd_cyc = 0;
    int          rd_count = 0;

    sin_table_reader #(
        .ACC_W (16),
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tune_wr     (tune_wr),
        .tune_in     (tune_in),
        .rd          (rd),
        .addr        (addr),
        .d_in        (d_in),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd) begin
            d_in <= rom[addr];
        end else begin
            d_in <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        tune_wr = 1'b0;
        sample_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic set_tune(input logic [15:0] v);
        tune_wr = 1'b1;
        tune_in = v;
        cycle();
        tune_wr = 1'b0;
    endtask

    // Entered just before the edge that starts FETCH; leaves the DUT in HOLD.
    task automatic run_sample(input logic [7:0] a);
        cycle();
        tune_wr = 1'b0;
        rd_cyc = cyc;
        check("rd_pulse", 32'(rd), 32'd1);
        check("addr", 32'(addr), 32'(a));
        cycle();
        check("rd_low", 32'(rd), 32'd0);
        check("valid_low", 32'(sample_valid), 32'd0);
        cycle();
        check("valid", 32'(sample_valid), 32'd1);
        check("sample", 32'(sample), 32'(rom[a]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($rtoi(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));
        end

        do_reset();
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);

        // basic sweep
        set_tune(16'h0100);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_sample(8'(k));
        end

        // quarter-turn steps with wrap
        do_reset();
        set_tune(16'h4000);
        en = 1'b1;
        run_sample(8'h00);
        check("wrap_s0", 32'(sample), 32'h80);
        run_sample(8'h40);
        check("wrap_peak", 32'(sample), 32'hFF);
        run_sample(8'h80);
        check("wrap_s2", 32'(sample), 32'h80);
        run_sample(8'hC0);
        check("wrap_trough", 32'(sample), 32'h00);
        run_sample(8'h00);
        check("wrap_s4", 32'(sample), 32'h80);

        // carry discard on every step
        do_reset();
        set_tune(16'hFF00);
        en = 1'b1;
        run_sample(8'h00);
        run_sample(8'hFF);
        run_sample(8'hFE);

        // backpressure: five stall cycles stretch the period to 8
        do_reset();
        set_tune(16'h0100);
        en = 1'b1;
        cycle();
        first_rd_cyc = cyc;
        check("bp_rd0", 32'(rd), 32'd1);
        cycle();
        sample_ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(sample_valid), 32'd1);
            check("bp_sample", 32'(sample), 32'(rom[0]));
            check("bp_rd", 32'(rd), 32'd0);
            cycle();
        end
        check("bp_valid_last", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        run_sample(8'h01);
        check("bp_period", 32'(rd_cyc - first_rd_cyc), 32'd8);

        // tune change while holding addr 0x05
        do_reset();
        set_tune(16'h0100);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_sample(8'(k));
        end
        tune_wr = 1'b1;
        tune_in = 16'h0200;
        run_sample(8'h06);
        run_sample(8'h08);
        run_sample(8'h0A);

        // enable dropped during FETCH
        do_reset();
        set_tune(16'h0100);
        en = 1'b1;
        run_sample(8'h00);
        cycle();
        check("drop_rd", 32'(rd), 32'd1);
        check("drop_addr", 32'(addr), 32'h01);
        en = 1'b0;
        cycle();
        cycle();
        check("drop_valid", 32'(sample_valid), 32'd1);
        check("drop_sample", 32'(sample), 32'(rom[1]));
        cycle();
        check("drop_idle_valid", 32'(sample_valid), 32'd0);
        rd_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (rd) rd_count++;
            cycle();
        end
        check("drop_no_rd", 32'(rd_count), 32'd0);
        en = 1'b1;
        run_sample(8'h02);

        // reset during FETCH
        do_reset();
        set_tune(16'h0100);
        en = 1'b1;
        run_sample(8'h00);
        run_sample(8'h01);
        cycle();
        check("rf_rd", 32'(rd), 32'd1);
        check("rf_addr", 32'(addr), 32'h02);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rf_rd_after", 32'(rd), 32'd0);
        check("rf_valid_after", 32'(sample_valid), 32'd0);
        check("rf_addr_after", 32'(addr), 32'd0);
        check("rf_sample_after", 32'(sample), 32'd0);
        run_sample(8'h00);
        run_sample(8'h00);
        run_sample(8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sin_table_reader.md
# sin_table_reader

Synchronous sine-sample generator and the read-side master of the 256-entry `sin_table` ROM. It holds a phase accumulator and a programmable tuning word, issues `rd`/`addr` requests to the table, and captures the returned byte. Each sample is presented to a downstream consumer through a valid/ready handshake. It sits between `sin_table` and any DAC/PWM or stream stage that consumes the waveform.

## Interface
- `ACC_W`, default 16: phase accumulator and tuning word width.
- `ADDR_W`, default 8: table address width; `addr = phase[ACC_W-1 -: ADDR_W]`.
- `DATA_W`, default 8: table data and sample width.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: run enable.
- `tune_wr`, input, 1: load strobe for `tune_in`.
- `tune_in`, input, ACC_W: phase increment per sample.
- `rd`, output, 1: registered read strobe to `sin_table`.
- `addr`, output, ADDR_W: registered table address.
- `d_in`, input, DATA_W: table read data (`sin_table.d_out`). Valid one cycle after the cycle `rd=1` is sampled.
- `sample`, output, DATA_W: registered output sample.
- `sample_valid`, output, 1: sample present.
- `sample_ready`, input, 1: consumer accepts.

## Operation
- Registers:
  - `phase` (ACC_W), `tune` (ACC_W), `state`, plus the output registers `rd`, `addr`, `sample`, `sample_valid`.
- Reset values: `phase=0`, `tune=0`, `rd=0`, `addr=0`, `sample=0`, `sample_valid=0`, `state=IDLE`.
- `rst` has priority over every other input.
- `tune_wr=1`: `tune<=tune_in` on that edge, in any state. The new value is used by the next phase update, including one on the same edge.
- State machine:
  - IDLE: `rd=0`, `sample_valid=0`. If `en`: `rd<=1`, `addr<=phase` MSBs, go to FETCH.
  - FETCH: `rd=1` for exactly this one cycle; the table samples `addr`. Next edge: `rd<=0`, go to CAPTURE.
  - CAPTURE: `d_in` is valid. Next edge: `sample<=d_in`, `sample_valid<=1`, `phase<=phase+tune` (mod 2^ACC_W), go to HOLD.
  - HOLD: `sample` and `sample_valid` are held stable while `sample_ready=0`. On an edge with `sample_ready=1`: `sample_valid<=0`.
    - If `en=1`: `rd<=1`, `addr<=phase` MSBs (already-updated phase), go to FETCH.
    - Otherwise go to IDLE.
- Arithmetic:
  - Unsigned add; carry out of bit ACC_W-1 is discarded.
  - Only the top ADDR_W bits address the table; lower bits are fractional phase.
- Boundary conditions:
  - Dropping `en` while in FETCH, CAPTURE or HOLD does not abort. The in-flight sample completes and is handshaken, then the block returns to IDLE.
  - `en` is ignored except in IDLE and at the HOLD handshake edge.
  - `tune=0`: the same address repeats indefinitely. This is legal.
  - Phase wrap from 0xFF00 + 0x0100 gives 0x0000, so `addr` goes 0xFF → 0x00.
  - Reset mid-operation returns all registers to reset values on that edge. A pending sample is discarded and no `rd` pulse is emitted in the following cycle.
  - `d_in` is ignored outside CAPTURE.

## Timing
- Read latency: `rd` is high in cycle N, `d_in` is used in cycle N+1, and `sample_valid` rises at the edge ending cycle N+1.
- From `en` sampled in IDLE to first `sample_valid`: 3 edges.
- With `sample_ready` held high and `en` high: one sample every 3 cycles.
  - `sample_valid` is high 1 of every 3 cycles.
  - `rd` is high 1 of every 3 cycles.
- Backpressure: each stall cycle in HOLD adds exactly one cycle to the period. `rd` stays 0 while stalled.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic sweep:
  - Stimulus: reset, `tune=0x0100`, `en=1`, ready high.
  - Required: `addr` sequence 0x00, 0x01, 0x02, …, with `rd` pulses 3 cycles apart. Each `sample` equals the table content at the preceding `addr`. First `sample_valid` occurs 3 edges after `en`.
- Wrap-around:
  - Stimulus: `tune=0x4000`.
  - Required: `addr` sequence 0x00, 0x40, 0x80, 0xC0, 0x00. Samples are 0x80 → peak → 0x80 → trough → 0x80, within table rounding.
- Backpressure:
  - Stimulus: `sample_ready` low for 5 cycles at the first valid.
  - Required: `sample` and `sample_valid` stable, `rd=0` throughout. The next `rd` occurs the cycle after `sample_ready` rises, and the period becomes 8.
- Tune change:
  - Stimulus: pulse `tune_wr` with 0x0200 while in HOLD, while `addr=0x05` (`tune=0x0100`).
  - Required: next `addr=0x06`, then 0x08, 0x0A.
- Enable drop:
  - Stimulus: deassert `en` in FETCH.
  - Required: that sample is still produced and handshaken, the block then goes to IDLE, and no further `rd` is issued. Reasserting `en` resumes from the held phase.
- Reset mid-FETCH:
  - Stimulus: assert `rst` for one cycle during FETCH.
  - Required: next cycle `rd=0`, `sample_valid=0`, `addr=0`, `phase=0`, `tune=0`. With `en=1`, no `rd` pulse occurs until after `rst` is released.
